// File: rtl/wb_arb_if.sv
// Bus bundle between the write-back arbiter and its surroundings: the MEM/WB pipe,
// the multi-cycle unit and the register-file write port. conflict_cnt exists only with WB_ARB_STATS_EN.
interface wb_arb_if;
  logic        pipe_we;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_dest;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_dest, pipe_data, mc_valid, mc_dest, mc_data,
    output mc_ready, rf_we, rf_addr, rf_wdata, stall_pipe
`ifdef WB_ARB_STATS_EN
    , output conflict_cnt
`endif
  );

  // Pipeline / multi-cycle unit / register-file side.
  modport master (
    output pipe_we, pipe_dest, pipe_data, mc_valid, mc_dest, mc_data,
    input  mc_ready, rf_we, rf_addr, rf_wdata, stall_pipe
`ifdef WB_ARB_STATS_EN
    , input conflict_cnt
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// Single register-file write port shared by the MEM/WB pipe and a multi-cycle unit, with a
// 2-entry result FIFO and a starvation stall. Define WB_ARB_STATS_EN to add conflict_cnt.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_arb_if.slave  bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB, FORCE} state_e;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

  state_e        state_q, state_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          stall_pipe_q, stall_pipe_d;
  wb_entry_t     fifo_q [2];

  logic          fifo_empty;
  logic          fifo_full;
  logic          mc_ready;
  logic          mc_live;
  logic          pipe_live;
  logic          push;
  logic          pop;
  logic          direct;
  wb_entry_t     head;
  wb_entry_t     mc_entry;

  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign mc_ready   = !fifo_full;
  assign head       = fifo_q[rd_ptr_q];
  assign mc_entry   = '{dest: bus.mc_dest, data: bus.mc_data};
  // Results for r0 complete the handshake but never reach the port or the FIFO.
  assign mc_live    = bus.mc_valid && mc_ready && (bus.mc_dest != 5'd0);
  assign pipe_live  = bus.pipe_we && (bus.pipe_dest != 5'd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    pop          = 1'b0;
    direct       = 1'b0;

    if (state_q == ARB) begin
      if (pipe_live) begin
        rf_we_d    = 1'b1;
        rf_addr_d  = bus.pipe_dest;
        rf_wdata_d = bus.pipe_data;
      end else if (!fifo_empty) begin
        pop        = 1'b1;
        rf_we_d    = 1'b1;
        rf_addr_d  = head.dest;
        rf_wdata_d = head.data;
      end else if (mc_live) begin
        direct     = 1'b1;
        rf_we_d    = 1'b1;
        rf_addr_d  = bus.mc_dest;
        rf_wdata_d = bus.mc_data;
      end

      if (fifo_empty || pop) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end

      if (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) begin
        state_d = FORCE;
      end
    end else begin
      // Pipe is held by stall_pipe and re-presents its write in the next ARB cycle.
      if (!fifo_empty) begin
        pop        = 1'b1;
        rf_we_d    = 1'b1;
        rf_addr_d  = head.dest;
        rf_wdata_d = head.data;
      end
      starve_cnt_d = '0;
      state_d      = ARB;
    end

    stall_pipe_d = (state_d == FORCE);
  end

  assign push = mc_live && !direct;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= ARB;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= 5'd0;
      rf_wdata_q   <= 32'd0;
      stall_pipe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      stall_pipe_q <= stall_pipe_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mc_entry;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (push && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.conflict_cnt = conflict_cnt_q;
`endif

  assign bus.mc_ready   = mc_ready;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.stall_pipe = stall_pipe_q;

endmodule
